muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit, parametrised successor to the single-cycle ALU.

---
 rtl/muldiv_unit_pkg.sv | 37 +++
 rtl/muldiv_unit_cond_negate.sv | 12 +
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: funct3 op codes, FSM states
// and the operand-signedness decode used at acceptance.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // MUL ignores signedness because its low word is identical either way
    function automatic logic a_is_signed(input op_e op);
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic b_is_signed(input op_e op);
        case (op)
            OP_MULH, OP_DIV, OP_REM: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// Conditional two's complement: out = neg ? -in : in.
module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] out_o
);

    assign out_o = neg_i ? ((~in_i) + WIDTH'(1)) : in_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide
// on unsigned magnitudes, with sign correction folded into the final step.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter bit EARLY_SPECIAL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int W2    = 2 * WIDTH;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [W2-1:0]     prod_q, prod_d;
    logic [WIDTH-1:0]  divisor_q, divisor_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              dz_q, dz_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              div_zero_q, div_zero_d;

    op_e               op_in_s;
    logic              sa_s, sb_s, in_is_div_s, b_zero_s, ovf_s, special_s;
    logic [WIDTH-1:0]  abs_a_s, abs_b_s, special_res_s, final_s;
    logic [WIDTH:0]    mul_sum_s, div_sh_s, div_trial_s;
    logic [W2-1:0]     mul_next_s, div_next_s, step_s, fix_in_s, fix_out_s;

    assign op_in_s     = op_e'(op);
    assign sa_s        = a_is_signed(op_in_s) & a[WIDTH-1];
    assign sb_s        = b_is_signed(op_in_s) & b[WIDTH-1];
    assign in_is_div_s = op_in_s[2];
    assign b_zero_s    = (b == {WIDTH{1'b0}});
    assign ovf_s       = (op_in_s == OP_DIV || op_in_s == OP_REM) &&
                         (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}});
    assign special_s   = in_is_div_s && (b_zero_s || ovf_s);
    // Overflow only reaches here with a == most-negative, so 'a' doubles as the DIV answer
    assign special_res_s = b_zero_s ? (op_in_s[1] ? a : {WIDTH{1'b1}})
                                    : (op_in_s[1] ? {WIDTH{1'b0}} : a);

    cond_negate #(.WIDTH(WIDTH)) u_abs_a (.in_i(a), .neg_i(sa_s), .out_o(abs_a_s));
    cond_negate #(.WIDTH(WIDTH)) u_abs_b (.in_i(b), .neg_i(sb_s), .out_o(abs_b_s));

    // prod_q holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide
    assign mul_sum_s   = {1'b0, prod_q[W2-1:WIDTH]} +
                         (prod_q[0] ? {1'b0, divisor_q} : {(WIDTH+1){1'b0}});
    assign mul_next_s  = {mul_sum_s, prod_q[WIDTH-1:1]};
    assign div_sh_s    = prod_q[W2-1:WIDTH-1];
    assign div_trial_s = div_sh_s - {1'b0, divisor_q};
    assign div_next_s  = div_trial_s[WIDTH]
                       ? {div_sh_s[WIDTH-1:0],    prod_q[WIDTH-2:0], 1'b0}
                       : {div_trial_s[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    assign step_s      = op_q[2] ? div_next_s : mul_next_s;

    assign fix_in_s = op_q[2]
                    ? {{WIDTH{1'b0}}, (op_q[1] ? step_s[W2-1:WIDTH] : step_s[WIDTH-1:0])}
                    : step_s;
    cond_negate #(.WIDTH(W2)) u_fix (.in_i(fix_in_s), .neg_i(neg_q), .out_o(fix_out_s));

    // A zero divisor leaves an all-ones quotient that the sign fix would corrupt
    always_comb begin
        if (dz_q && !op_q[1]) begin
            final_s = {WIDTH{1'b1}};
        end else if (op_q[2] || op_q == OP_MUL) begin
            final_s = fix_out_s[WIDTH-1:0];
        end else begin
            final_s = fix_out_s[W2-1:WIDTH];
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        prod_d     = prod_q;
        divisor_d  = divisor_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        dz_d       = dz_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !kill) begin
                    op_d      = op_in_s;
                    prod_d    = {{WIDTH{1'b0}}, abs_a_s};
                    divisor_d = abs_b_s;
                    cnt_d     = {CNT_W{1'b0}};
                    neg_d     = (in_is_div_s && op_in_s[1]) ? sa_s : (sa_s ^ sb_s);
                    dz_d      = in_is_div_s && b_zero_s;
                    if (EARLY_SPECIAL && special_s) begin
                        result_d   = special_res_s;
                        div_zero_d = b_zero_s;
                        state_d    = S_DONE;
                    end else begin
                        state_d    = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    prod_d = step_s;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_d   = final_s;
                        div_zero_d = dz_q;
                        state_d    = S_DONE;
                    end else begin
                        state_d    = S_CALC;
                    end
                end
            end
            S_DONE: begin
                if (kill || out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_MUL;
            prod_q     <= {W2{1'b0}};
            divisor_q  <= {WIDTH{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            neg_q      <= 1'b0;
            dz_q       <= 1'b0;
            result_q   <= {WIDTH{1'b0}};
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            prod_q     <= prod_d;
            divisor_q  <= divisor_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            dz_q       <= dz_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: two units (early special-case exit on/off) share stimulus;
// expected results are queued at issue and compared on completion.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam logic [W-1:0] MIN = 32'h8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, in_valid, kill, out_ready;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         in_ready0, out_valid0, div_zero0;
    logic         in_ready1, out_valid1, div_zero1;
    logic [W-1:0] result0, result1;

    muldiv_unit #(.WIDTH(W), .EARLY_SPECIAL(1'b1)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .op(op),
        .a(a), .b(b), .kill(kill), .out_valid(out_valid0), .out_ready(out_ready),
        .result(result0), .div_zero(div_zero0));

    muldiv_unit #(.WIDTH(W), .EARLY_SPECIAL(1'b0)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1), .op(op),
        .a(a), .b(b), .kill(kill), .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1), .div_zero(div_zero1));

    typedef struct {
        logic [W-1:0] res;
        logic         dz;
        int           lat;
    } exp_t;

    typedef struct {
        logic [2:0]   f;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] res;
        logic         dz;
        logic         sp;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit arithmetic plus the RISC-V special-case values
    function automatic void model(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic dz, output logic sp);
        logic signed [63:0] sx, sy, ux, uy, p;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'h0, x};
        uy = {32'h0, y};
        dz = 1'b0;
        sp = 1'b0;
        r  = '0;
        case (f)
            3'd0: begin p = sx * sy; r = p[31:0];  end
            3'd1: begin p = sx * sy; r = p[63:32]; end
            3'd2: begin p = sx * uy; r = p[63:32]; end
            3'd3: begin p = ux * uy; r = p[63:32]; end
            3'd4, 3'd6: begin
                if (y == 32'h0) begin
                    dz = 1'b1; sp = 1'b1;
                    r  = (f == 3'd4) ? 32'hFFFF_FFFF : x;
                end else if (x == MIN && y == 32'hFFFF_FFFF) begin
                    sp = 1'b1;
                    r  = (f == 3'd4) ? MIN : 32'h0;
                end else begin
                    p = (f == 3'd4) ? (sx / sy) : (sx % sy);
                    r = p[31:0];
                end
            end
            3'd5, 3'd7: begin
                if (y == 32'h0) begin
                    dz = 1'b1; sp = 1'b1;
                    r  = (f == 3'd5) ? 32'hFFFF_FFFF : x;
                end else begin
                    r = (f == 3'd5) ? (x / y) : (x % y);
                end
            end
            default: r = '0;
        endcase
    endfunction

    task automatic push_exp(input logic [W-1:0] r, input logic dz, input logic sp);
        exp_t e;
        e.res = r;
        e.dz  = dz;
        e.lat = sp ? 0 : W;
        q0.push_back(e);
        e.lat = W;
        q1.push_back(e);
    endtask

    // Present one request; returns just after the accepting edge with operands scrambled
    task automatic issue(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        in_valid = 1'b1; op = f; a = x; b = y;
        check("in_ready0_before_issue", in_ready0, 1'b1);
        check("in_ready1_before_issue", in_ready1, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 3'($urandom);
        a  = $urandom;
        b  = $urandom;
    endtask

    task automatic complete(input int hold);
        int lat0 = -1;
        int lat1 = -1;
        logic [W-1:0] r0s, r1s;
        exp_t e;
        for (int c = 0; c <= W + 4; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (out_valid0 && lat0 < 0) lat0 = c;
            if (out_valid1 && lat1 < 0) lat1 = c;
            if (lat0 >= 0 && lat1 >= 0) break;
        end
        check("ready_valid_excl0", in_ready0 & out_valid0, 1'b0);
        check("ready_valid_excl1", in_ready1 & out_valid1, 1'b0);
        r0s = result0;
        r1s = result1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("bp_valid0", out_valid0, 1'b1);
            check("bp_stable0", result0, r0s);
            check("bp_in_ready0", in_ready0, 1'b0);
            check("bp_valid1", out_valid1, 1'b1);
            check("bp_stable1", result1, r1s);
        end
        check("q0_nonempty", q0.size() != 0, 1'b1);
        check("q1_nonempty", q1.size() != 0, 1'b1);
        if (q0.size() != 0) begin
            e = q0.pop_front();
            check("latency0", lat0, e.lat);
            check("result0", result0, e.res);
            check("div_zero0", div_zero0, e.dz);
        end
        if (q1.size() != 0) begin
            e = q1.pop_front();
            check("latency1", lat1, e.lat);
            check("result1", result1, e.res);
            check("div_zero1", div_zero1, e.dz);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("accept_valid0", out_valid0, 1'b0);
        check("accept_in_ready0", in_ready0, 1'b1);
        check("accept_valid1", out_valid1, 1'b0);
        check("accept_in_ready1", in_ready1, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        logic [W-1:0] r, x, y;
        logic dz, sp, seen;
        logic [2:0] f;

        reset = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
        op = 3'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready0", in_ready0, 1'b1);
        check("rst_out_valid0", out_valid0, 1'b0);
        check("rst_result0", result0, 32'h0);
        check("rst_div_zero0", div_zero0, 1'b0);
        check("rst_in_ready1", in_ready1, 1'b1);
        check("rst_out_valid1", out_valid1, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors with hand-derived expectations
        vecs.push_back('{3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0});
        vecs.push_back('{3'd1, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 1'b0, 1'b0});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{3'd1, MIN,          MIN,          32'h4000_0000, 1'b0, 1'b0});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0, 1'b0});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{3'd5, 32'd100,      32'd7,        32'd14,        1'b0, 1'b0});
        vecs.push_back('{3'd7, 32'd100,      32'd7,        32'd2,         1'b0, 1'b0});
        vecs.push_back('{3'd4, 32'd5,        32'd0,        32'hFFFF_FFFF, 1'b1, 1'b1});
        vecs.push_back('{3'd4, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFF, 1'b1, 1'b1});
        vecs.push_back('{3'd7, 32'd5,        32'd0,        32'd5,         1'b1, 1'b1});
        vecs.push_back('{3'd6, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 1'b1, 1'b1});
        vecs.push_back('{3'd4, MIN,          32'hFFFF_FFFF, MIN,           1'b0, 1'b1});
        vecs.push_back('{3'd6, MIN,          32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1});
        foreach (vecs[i]) begin
            push_exp(vecs[i].res, vecs[i].dz, vecs[i].sp);
            issue(vecs[i].f, vecs[i].x, vecs[i].y);
            complete(0);
        end

        // Backpressure: hold out_ready low for 10 cycles
        push_exp(32'd14, 1'b0, 1'b0);
        issue(3'd5, 32'd100, 32'd7);
        complete(10);

        // Kill during CALC cycle 5
        issue(3'd0, 32'd7, 32'd3);
        repeat (5) @(posedge clk);
        @(negedge clk); kill = 1'b1;
        @(posedge clk); #1; kill = 1'b0;
        check("kill_calc_in_ready0", in_ready0, 1'b1);
        check("kill_calc_in_ready1", in_ready1, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < W + 8; c++) begin
            @(posedge clk); #1;
            seen = seen | out_valid0 | out_valid1;
        end
        check("kill_calc_no_valid", seen, 1'b0);

        // Kill together with in_valid in IDLE: request is dropped
        @(negedge clk);
        in_valid = 1'b1; op = 3'd4; a = 32'd5; b = 32'd0; kill = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        check("kill_idle_in_ready0", in_ready0, 1'b1);
        check("kill_idle_in_ready1", in_ready1, 1'b1);
        check("kill_idle_out_valid0", out_valid0, 1'b0);

        // Kill while DONE
        issue(3'd4, 32'd5, 32'd0);
        for (int c = 0; c < W + 4 && !out_valid1; c++) begin
            @(posedge clk); #1;
        end
        check("kill_done_pre_valid0", out_valid0, 1'b1);
        check("kill_done_pre_valid1", out_valid1, 1'b1);
        @(negedge clk); kill = 1'b1;
        @(posedge clk); #1; kill = 1'b0;
        check("kill_done_valid0", out_valid0, 1'b0);
        check("kill_done_valid1", out_valid1, 1'b0);
        check("kill_done_in_ready0", in_ready0, 1'b1);

        // Reset mid-CALC, then a fresh MULHU 3*5
        issue(3'd0, 32'd7, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        #1;
        check("midrst_in_ready0", in_ready0, 1'b1);
        check("midrst_out_valid0", out_valid0, 1'b0);
        check("midrst_result0", result0, 32'h0);
        check("midrst_div_zero0", div_zero0, 1'b0);
        check("midrst_in_ready1", in_ready1, 1'b1);
        check("midrst_result1", result1, 32'h0);
        @(negedge clk); reset = 1'b0;
        push_exp(32'h0, 1'b0, 1'b0);
        issue(3'd3, 32'd3, 32'd5);
        complete(0);

        // Random soak against the reference model, biased toward special cases
        for (int n = 0; n < 40; n++) begin
            f = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'h0;
                1: begin x = MIN; y = 32'hFFFF_FFFF; end
                2: y = 32'($urandom_range(1, 15));
                default: ;
            endcase
            model(f, x, y, r, dz, sp);
            push_exp(r, dz, sp);
            issue(f, x, y);
            complete(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
